aes_dec_round_engine: RTL
=========================

Name: aes_dec_round_engine

Overview:
- Iterative AES inverse-cipher datapath; performs one decryption round per clock over a 128-bit state register.
- Drives the 128-bit inverse S-box lookup (aes_inv_sbox) through sbox_addr / sbox_data and consumes its result each round.
- Round keys are fetched from the key-schedule store by index.
- Sits between the crypto-accelerator command front end (ciphertext in) and its writeback (plaintext out).

Parameters:
- NR, 10, number of rounds (10/12/14 for AES-128/192/256); rk_idx counts NR..0.
- IDXW, 4, width of rk_idx; must satisfy 2**IDXW > NR.

Ports:
- clk  input  1  clock
- rst  input  1  reset; one clock, synchronous, active-high
- in_valid  input  1  ciphertext offered
- in_ready  output  1  engine can accept ciphertext
- in_data  input  128  ciphertext; byte 0 = [127:120], column-major (column c = [127-32c -: 32])
- rk_idx  output  IDXW  round-key index requested this cycle
- rk_data  input  128  round key for rk_idx, combinationally valid in the same cycle
- sbox_addr  output  128  bytes to inverse-substitute, to aes_inv_sbox addr
- sbox_data  input  128  inverse-substituted bytes, from aes_inv_sbox data
- out_valid  output  1  plaintext available
- out_ready  input  1  consumer accepts plaintext
- out_data  output  128  plaintext, same byte order as in_data
- busy  output  1  high in ROUND or FINAL

Behaviour:
- FSM states: IDLE, ROUND, FINAL, DONE. Registers: st[127:0], rnd[IDXW-1:0].
- Reset: FSM to IDLE; st, rnd, out_data = 0; out_valid = 0; busy = 0; in_ready = 1 on the first cycle after reset.
- rk_idx: NR in IDLE and DONE; rnd in ROUND; 0 in FINAL.
- in_ready = (IDLE) or (DONE and out_ready). All other states drive 0.
- Accept (in_valid & in_ready):
  - st <= in_data ^ rk_data, where rk_idx = NR at that time.
  - rnd <= NR-1; next state ROUND.
- sbox_addr = InvShiftRows(st), combinational. Row r rotates right by r byte positions: new byte (r,c) = old byte (r,(c-r) mod 4).
- ROUND (each cycle):
  - t = sbox_data ^ rk_data; st <= InvMixColumns(t).
  - InvMixColumns uses coefficients {0e,0b,0d,09} in GF(2^8), polynomial 0x11b, via an xtime chain. No multipliers.
  - If rnd == 1: next state FINAL. Otherwise rnd <= rnd-1.
- FINAL: st <= sbox_data ^ rk_data (no InvMixColumns); out_valid <= 1; next state DONE.
- DONE:
  - out_data = st; out_valid held high and out_data held stable until out_ready.
  - On out_ready without in_valid: out_valid <= 0, next state IDLE.
  - On out_ready with in_valid: back-to-back accept of the next block in that same cycle, next state ROUND, out_valid <= 0.
- Latency: accept at edge E → out_valid high after edge E+NR. NR=10 gives 10 cycles. Throughput is one block per NR+1 cycles.
- in_valid while busy is ignored; there is no queueing and the upstream holds its data.
- sbox_addr toggles in IDLE/DONE; the downstream S-box is combinational, so this is harmless.
- Reset asserted mid-operation (any state) aborts the operation: next cycle IDLE, out_valid 0, st cleared, no partial output emitted.
- rk_data is sampled only in the accept cycle, ROUND and FINAL; its value is don't-care otherwise.

Test Plan:
- FIPS-197 C.1 decrypt, NR=10, key 000102030405060708090a0b0c0d0e0f, schedule model answering rk_idx. Stimulus: in_data=69c4e0d86a7b0430d8cdb78070b4c55a with rk10=13111d7fe3944a17f307a78b4d2b30c5 at accept. Required: out_data=00112233445566778899aabbccddeeff; out_valid rises exactly 10 cycles after the accept edge; rk_idx sequence 10,9,…,1,0.
- Backpressure: hold out_ready=0 for 7 cycles after out_valid. Required: out_valid and out_data stable; in_ready=0; a new in_valid is not accepted.
- Back-to-back: in_valid held high with two blocks (C.1 vector, then its ciphertext with byte 15 XOR 01). Required: second accept occurs in the same cycle as the first out_ready handshake; the two results arrive 11 cycles apart; first result matches the C.1 plaintext.
- Reset mid-round: assert rst for 1 cycle when rk_idx=5. Required: next cycle IDLE, in_ready=1, out_valid=0, busy=0, out_data=0. A new C.1 decrypt afterwards yields the correct plaintext.
- All-zero key, all-zero ciphertext vs. a software AES model. Required: bit-exact match. Also 1000 random key/ciphertext pairs with random out_ready stalls: all match the model; no out_valid is dropped or duplicated.
- NR=14 build, FIPS-197 C.3 (key 00…1f, ciphertext 8ea2b7ca516745bfeafc49904b496089). Required: 00112233445566778899aabbccddeeff after 14 cycles.

Source files
------------

// File: rtl/aes_dec_round_engine.sv
// Iterative AES inverse cipher: one decryption round per clock over a 128-bit state,
// with an external combinational inverse S-box and an indexed round-key store.
module aes_dec_round_engine #(
  parameter int NR   = 10,
  parameter int IDXW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    in_data,
  output logic [IDXW-1:0] rk_idx,
  input  logic [127:0]    rk_data,
  output logic [127:0]    sbox_addr,
  input  logic [127:0]    sbox_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    out_data,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [IDXW-1:0] IDX_NR   = IDXW'(NR);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NR - 1);

  state_t          state_r;
  logic [127:0]    st_r;
  logic [IDXW-1:0] rnd_r;
  logic            out_valid_r;
  logic            busy_r;
  logic [127:0]    out_data_r;
  logic            in_ready_s;
  logic            accept_s;
  logic [127:0]    add_key_s;
  logic [IDXW-1:0] rk_idx_s;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Coefficients 0e/0b/0d/09 built from x2, x4, x8 so no GF multiplier is needed.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = 128'd0;
    for (int c = 0; c < 4; c++) begin
      r[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    return r;
  endfunction

  // Byte (r,c) lives at index 4c+r; row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        r[127-8*(4*c+rw) -: 8] = s[127-8*(4*((c-rw+4)%4)+rw) -: 8];
      end
    end
    return r;
  endfunction

  // Handshake and round-key index decode from the current state.
  always_comb begin
    in_ready_s = 1'b0;
    rk_idx_s   = IDX_NR;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        rk_idx_s   = IDX_NR;
      end
      ROUND: begin
        in_ready_s = 1'b0;
        rk_idx_s   = rnd_r;
      end
      FINAL: begin
        in_ready_s = 1'b0;
        rk_idx_s   = {IDXW{1'b0}};
      end
      DONE: begin
        in_ready_s = out_ready;
        rk_idx_s   = IDX_NR;
      end
      default: begin
        in_ready_s = 1'b0;
        rk_idx_s   = IDX_NR;
      end
    endcase
  end

  assign accept_s  = in_valid & in_ready_s;
  assign add_key_s = sbox_data ^ rk_data;
  assign sbox_addr = inv_shift_rows(st_r);
  assign in_ready  = in_ready_s;
  assign rk_idx    = rk_idx_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;

  // Round FSM and datapath state; reset aborts any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      st_r        <= 128'd0;
      rnd_r       <= {IDXW{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= 128'd0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            st_r    <= in_data ^ rk_data;
            rnd_r   <= IDX_LAST;
            busy_r  <= 1'b1;
            state_r <= ROUND;
          end
        end
        ROUND: begin
          st_r <= inv_mix_columns(add_key_s);
          if (rnd_r == IDXW'(1)) begin
            state_r <= FINAL;
          end else begin
            rnd_r <= rnd_r - IDXW'(1);
          end
        end
        FINAL: begin
          st_r        <= add_key_s;
          out_data_r  <= add_key_s;
          out_valid_r <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (accept_s) begin
              st_r    <= in_data ^ rk_data;
              rnd_r   <= IDX_LAST;
              busy_r  <= 1'b1;
              state_r <= ROUND;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
